// File: rtl/trig_pipe_monitor.sv
// trig_pipe_monitor
//
// Configurable rare-event trigger model. The monitored vector is delayed through a
// DEPTH-stage register pipeline, compared against a masked pattern, and a run-length
// counter tracks consecutive matching cycles. When the run reaches THRESH the block
// latches a sticky trigger and emits a one-cycle pulse.
//
// Parameters
//   WIDTH   monitored channels (1..32)
//   DEPTH   delay stages ahead of the compare (1..8)
//   CNT_W   run-length counter width (2..8)
//   THRESH  consecutive matches needed to trigger (1..2^CNT_W-1)
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-low reset
//   din         monitored channel values, sampled every edge
//   pattern     required value per channel (quasi-static)
//   mask        1 = channel takes part in the compare, 0 = don't care
//   arm         level enable for run counting
//   clr         synchronous clear of counter, trigger and FSM
//   match_q     registered compare result of the delayed vector
//   hit_cnt     current consecutive-match count
//   trig        sticky trigger
//   trig_pulse  one-cycle pulse on trigger entry
//   busy        FSM is in ARMED or COUNT

module trig_pipe_monitor #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned CNT_W  = 4,
   parameter int unsigned THRESH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic [WIDTH-1:0] pattern,
   input  logic [WIDTH-1:0] mask,
   input  logic             arm,
   input  logic             clr,
   output logic             match_q,
   output logic [CNT_W-1:0] hit_cnt,
   output logic             trig,
   output logic             trig_pulse,
   output logic             busy
);

   // Reject parameter sets the counter cannot represent.
   if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("trig_pipe_monitor: WIDTH must be 1..32");
   end
   if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
      $error("trig_pipe_monitor: DEPTH must be 1..8");
   end
   if (CNT_W < 2 || CNT_W > 8) begin : g_bad_cnt_w
      $error("trig_pipe_monitor: CNT_W must be 2..8");
   end
   if (THRESH < 1 || THRESH > (1 << CNT_W) - 1) begin : g_bad_thresh
      $error("trig_pipe_monitor: THRESH must be 1..2^CNT_W-1");
   end

   localparam logic [CNT_W-1:0] ThreshVal = CNT_W'(THRESH);

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StArmed = 2'b01,
      StCount = 2'b10,
      StTrig  = 2'b11
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] stage_q [DEPTH];
   logic             cmp;
   logic [CNT_W-1:0] cnt_inc;

   // ---------------------------------------------------------------------------------
   // Delay pipeline: free-running, independent of arm, clr and FSM state.
   // ---------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   // Masked-off channels always compare true, so an all-zero mask matches anything.
   assign cmp = &((stage_q[DEPTH-1] ~^ pattern) | ~mask);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         match_q <= 1'b0;
      end else begin
         match_q <= cmp;
      end
   end

   // Counter stays below THRESH outside TRIG, so the increment cannot wrap.
   assign cnt_inc = hit_cnt + CNT_W'(1);

   // ---------------------------------------------------------------------------------
   // Run-length FSM. clr has priority over every other transition; TRIG is left only
   // through clr or reset.
   // ---------------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         hit_cnt    <= '0;
         trig       <= 1'b0;
         trig_pulse <= 1'b0;
      end else begin
         trig_pulse <= 1'b0;
         if (clr) begin
            state_q <= StIdle;
            hit_cnt <= '0;
            trig    <= 1'b0;
         end else begin
            case (state_q)
               StIdle: begin
                  if (arm) begin
                     state_q <= StArmed;
                  end
               end
               StArmed, StCount: begin
                  if (!arm) begin
                     state_q <= StIdle;
                     hit_cnt <= '0;
                  end else if (!match_q) begin
                     // A single gap restarts the run; runs never accumulate.
                     state_q <= StArmed;
                     hit_cnt <= '0;
                  end else if (cnt_inc == ThreshVal) begin
                     state_q    <= StTrig;
                     hit_cnt    <= ThreshVal;
                     trig       <= 1'b1;
                     trig_pulse <= 1'b1;
                  end else begin
                     state_q <= StCount;
                     hit_cnt <= cnt_inc;
                  end
               end
               StTrig: begin
                  trig <= 1'b1;
               end
               default: begin
                  state_q <= StIdle;
                  hit_cnt <= '0;
                  trig    <= 1'b0;
               end
            endcase
         end
      end
   end

   assign busy = (state_q == StArmed) || (state_q == StCount);

endmodule
